// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared encodings for the multiply/divide scheduler
package md_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    function automatic logic md_is_arith(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd4);
    endfunction

endpackage

// File: rtl/md_calc.sv
// rtl/md_calc.sv - combinational multiply/divide datapath on latched operands
module md_calc
    import md_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res,
    output logic        dz
);

    logic        signed_op;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_div;
    logic [63:0] prod_mag;
    logic [63:0] prod;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // Work on magnitudes so 0x80000000 / -1 falls out as 0x80000000 rem 0
    always_comb begin
        signed_op = (op == MD_MULT) || (op == MD_DIV);
        a_neg     = signed_op & rs[31];
        b_neg     = signed_op & rt[31];
        a_mag     = a_neg ? (32'd0 - rs) : rs;
        b_mag     = b_neg ? (32'd0 - rt) : rt;
        dz        = ((op == MD_DIV) || (op == MD_DIVU)) && (rt == 32'd0);
        b_div     = (b_mag == 32'd0) ? 32'd1 : b_mag;

        prod_mag  = {32'd0, a_mag} * {32'd0, b_mag};
        prod      = (a_neg ^ b_neg) ? (64'd0 - prod_mag) : prod_mag;

        q_mag     = a_mag / b_div;
        r_mag     = a_mag % b_div;
        quot      = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem       = a_neg ? (32'd0 - r_mag) : r_mag;

        hi_res    = 32'd0;
        lo_res    = 32'd0;
        case (op)
            MD_MULT, MD_MULTU: begin
                hi_res = prod[63:32];
                lo_res = prod[31:0];
            end
            MD_DIV, MD_DIVU: begin
                hi_res = rem;
                lo_res = quot;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// rtl/md_sched.sv - multiply/divide scheduler owning HI/LO and the MD stall request
module md_sched
    import md_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_valid,
    input  logic [2:0]  e_mdop,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        e_rdsel,
    input  logic        d_uses_md,
    output logic [31:0] e_mdrdata,
    output logic        busy,
    output logic        start,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    md_op_e           op_q, op_d;
    logic [31:0]      rs_q, rs_d;
    logic [31:0]      rt_q, rt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic [31:0]      hi_res;
    logic [31:0]      lo_res;
    logic             dz;

    md_calc u_calc (
        .op     (op_q),
        .rs     (rs_q),
        .rt     (rt_q),
        .hi_res (hi_res),
        .lo_res (lo_res),
        .dz     (dz)
    );

    assign start     = e_valid & md_is_arith(e_mdop) & (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RUN);
    assign md_stall  = d_uses_md & (start | busy);
    assign e_mdrdata = e_rdsel ? hi_q : lo_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    op_d    = md_op_e'(e_mdop);
                    rs_d    = e_rs;
                    rt_d    = e_rt;
                    cnt_d   = (e_mdop == MD_MULT || e_mdop == MD_MULTU) ? MULT_CNT : DIV_CNT;
                end else if (e_valid && e_mdop == MD_MTHI) begin
                    hi_d = e_rs;
                end else if (e_valid && e_mdop == MD_MTLO) begin
                    lo_d = e_rs;
                end
            end
            ST_RUN: begin
                // Ops arriving here are protocol violations and are dropped
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= 1) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    if (!dz) begin
                        hi_d = hi_res;
                        lo_d = lo_res;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= MD_NONE;
            rs_q    <= '0;
            rt_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// tb/tb_md_sched.sv - scoreboard bench for md_sched
module tb_md_sched;
    import md_pkg::*;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        e_valid;
    logic [2:0]  e_mdop;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        e_rdsel;
    logic        d_uses_md;
    logic [31:0] e_mdrdata;
    logic        busy;
    logic        start;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } hl_t;

    hl_t exp_q[$];
    int  errs   = 0;
    int  checks = 0;

    always #5 clk = ~clk;

    md_sched #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .e_valid   (e_valid),
        .e_mdop    (e_mdop),
        .e_rs      (e_rs),
        .e_rt      (e_rt),
        .e_rdsel   (e_rdsel),
        .d_uses_md (d_uses_md),
        .e_mdrdata (e_mdrdata),
        .busy      (busy),
        .start     (start),
        .md_stall  (md_stall),
        .hi        (hi),
        .lo        (lo)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        e_valid = 1'b0;
        e_mdop  = 3'd0;
    endtask

    task automatic write_hl(input string tag, input logic [2:0] op, input logic [31:0] val);
        @(negedge clk);
        e_valid = 1'b1;
        e_mdop  = op;
        e_rs    = val;
        #1 check_val({tag, "_start"}, start, 1'b0);
        @(negedge clk);
        idle_inputs();
        e_rdsel = (op == MD_MTHI);
        #1 check_val({tag, "_rd"}, e_mdrdata, val);
        check_val({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] rs, input logic [31:0] rt, input int lat,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic dstall, input logic inject);
        hl_t e;
        int  n;
        e.hi = exp_hi;
        e.lo = exp_lo;
        exp_q.push_back(e);

        @(negedge clk);
        e_valid   = 1'b1;
        e_mdop    = op;
        e_rs      = rs;
        e_rt      = rt;
        d_uses_md = dstall;
        #1 check_val({tag, "_start"}, start, 1'b1);
        check_val({tag, "_stall_t"}, md_stall, dstall);

        @(negedge clk);
        idle_inputs();
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            e_rs = $urandom;
            e_rt = $urandom;
            if (inject && n == 2) begin
                e_valid = 1'b1;
                e_mdop  = MD_MTHI;
            end else if (inject && n == 3) begin
                e_valid = 1'b1;
                e_mdop  = MD_MULT;
            end else begin
                idle_inputs();
            end
            #1 check_val({tag, "_stall_busy"}, md_stall, dstall);
            if (inject && (n == 2 || n == 3))
                check_val({tag, "_inject_start"}, start, 1'b0);
            n++;
            @(negedge clk);
        end
        idle_inputs();
        #1 check_val({tag, "_busy_len"}, 64'(n), 64'(lat));
        check_val({tag, "_stall_end"}, md_stall, 1'b0);
        e = exp_q.pop_front();
        check_val({tag, "_hi"}, hi, e.hi);
        check_val({tag, "_lo"}, lo, e.lo);
        d_uses_md = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        e_valid   = 1'b0;
        e_mdop    = 3'd0;
        e_rs      = 32'd0;
        e_rt      = 32'd0;
        e_rdsel   = 1'b0;
        d_uses_md = 1'b0;
        repeat (2) @(negedge clk);
        #1 check_val("rst_busy", busy, 1'b0);
        check_val("rst_hi", hi, 32'd0);
        check_val("rst_lo", lo, 32'd0);
        check_val("rst_start", start, 1'b0);
        reset = 1'b1;

        write_hl("mtlo", MD_MTLO, 32'hDEADBEEF);
        write_hl("mthi", MD_MTHI, 32'h0BADF00D);

        run_op("mult",  MD_MULT,  32'hFFFFFFFE, 32'd3, MULT_LAT, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b1, 1'b1);
        run_op("multu", MD_MULTU, 32'hFFFFFFFE, 32'd3, MULT_LAT, 32'h00000002, 32'hFFFFFFFA, 1'b0, 1'b0);
        run_op("div",   MD_DIV,   32'hFFFFFFF9, 32'd2, DIV_LAT,  32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 1'b0);
        run_op("divu",  MD_DIVU,  32'd100,      32'd7, DIV_LAT,  32'd2,        32'd14,       1'b0, 1'b1);
        run_op("divnd", MD_DIV,   32'd7,        32'hFFFFFFFE, DIV_LAT, 32'd1,  32'hFFFFFFFD, 1'b0, 1'b0);
        run_op("divov", MD_DIV,   32'h80000000, 32'hFFFFFFFF, DIV_LAT, 32'd0,  32'h80000000, 1'b0, 1'b0);

        write_hl("pre_hi", MD_MTHI, 32'h11);
        write_hl("pre_lo", MD_MTLO, 32'h22);
        run_op("div0",  MD_DIV,   32'd55,       32'd0, DIV_LAT,  32'h11,       32'h22,       1'b0, 1'b0);

        @(negedge clk);
        e_valid = 1'b0;
        e_mdop  = MD_MULT;
        e_rs    = 32'd9;
        e_rt    = 32'd9;
        #1 check_val("nv_start", start, 1'b0);
        @(negedge clk);
        idle_inputs();
        #1 check_val("nv_busy", busy, 1'b0);
        check_val("nv_hi", hi, 32'h11);
        check_val("nv_lo", lo, 32'h22);

        @(negedge clk);
        e_valid = 1'b1;
        e_mdop  = MD_MULT;
        e_rs    = 32'd3;
        e_rt    = 32'd4;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        #1 check_val("rr_busy", busy, 1'b0);
        check_val("rr_hi", hi, 32'd0);
        check_val("rr_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        #1 check_val("rr_busy_late", busy, 1'b0);
        check_val("rr_hi_late", hi, 32'd0);
        check_val("rr_lo_late", lo, 32'd0);
        check_val("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Multiply/divide scheduler for the 5-stage pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo from the E stage and runs a fixed-latency multi-cycle operation.
- Owns the HI/LO registers and serves mfhi/mflo reads.
- Raises a stall request so the hazard logic freezes D-stage MD instructions while the unit is busy.

Parameters:
- MULT_LAT, 5, cycles busy for mult/multu (legal 1..15)
- DIV_LAT, 10, cycles busy for div/divu (legal 1..15)

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state
- e_valid  in  1  E-stage holds a real instruction (0 = bubble)
- e_mdop  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo
- e_rs  in  32  forwarded rs value (FW_e_d1 path)
- e_rt  in  32  forwarded rt value (FW_e_d2 path)
- e_rdsel  in  1  read select for mfhi/mflo: 1 HI, 0 LO
- d_uses_md  in  1  D-stage instruction is any mult/div/mthi/mtlo/mfhi/mflo
- e_mdrdata  out  32  HI or LO per e_rdsel, combinational from registers
- busy  out  1  operation in flight
- start  out  1  combinational: e_valid & e_mdop in 1..4 & state IDLE
- md_stall  out  1  d_uses_md & (start | busy)
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (reset=0, async): state IDLE, counter 0, HI=LO=0, busy=0. Operand latches cleared. Any in-flight op is aborted; no late HI/LO write.
- States: IDLE, RUN.
- IDLE -> RUN when start=1:
  - latch e_rs, e_rt and the op at the edge;
  - counter = MULT_LAT for mult/multu, DIV_LAT for div/divu.
- RUN: busy=1; counter decrements each cycle.
  - When counter==1: the edge writes the result to HI/LO, state -> IDLE, busy falls.
- Timing: start in cycle T -> busy high T+1..T+LAT -> HI/LO show the new value from T+LAT+1.
- mthi/mtlo: e_valid & IDLE -> write e_rs to HI or LO at the edge; no busy.
- mfhi/mflo: read via e_mdrdata; no state change.
- Arithmetic:
  - mult: signed 32x32 -> 64; HI=[63:32], LO=[31:0].
  - multu: same, unsigned.
  - div: signed, truncating toward zero; LO=quotient, HI=remainder (remainder sign follows the dividend).
  - divu: unsigned.
- Division by zero: still takes DIV_LAT cycles; HI/LO unchanged.
- Signed 0x80000000 / -1: LO=0x80000000, HI=0.
- Compute from the latched operands only; changes on e_rs/e_rt during RUN have no effect.
- MD op presented while busy is a protocol violation (md_stall prevents it). The unit ignores it: no start, no latch, HI/LO untouched.
- e_valid=0: all of e_mdop is ignored.
- md_stall is purely combinational and has no reset dependency beyond busy.
- Same-cycle start and d_uses_md: md_stall=1 in that cycle.

Decomposition:
- Shared package md_pkg: op encodings (MD_NONE..MD_MTLO), state encoding (IDLE/RUN), counter width constant (4).
- One sub-module md_calc: combinational, takes latched op/operands and returns {hi_res, lo_res, dz} where dz flags divide-by-zero.
- md_sched holds the FSM, counter, latches and HI/LO.

Test Plan:
- Reset during RUN mid-multiply (cycle T+2) -> busy=0 immediately; HI=LO=0 after release; no write at T+5.
- mult rs=0xFFFFFFFE, rt=3 at T -> busy T+1..T+5; at T+6 HI=0xFFFFFFFF, LO=0xFFFFFFFA. Same operands with multu -> HI=0x00000002, LO=0xFFFFFFFA.
- div rs=0xFFFFFFF9 (-7), rt=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 100/7 -> LO=14, HI=2.
- div rt=0 with HI=0x11, LO=0x22 preloaded via mthi/mtlo -> busy for 10 cycles; HI=0x11, LO=0x22 unchanged.
- Stall check: mult at T with d_uses_md=1 held -> md_stall=1 for T..T+5 and 0 at T+6. Same with d_uses_md=0 -> md_stall=0 throughout. Op injected during busy -> ignored.
- mtlo 0xDEADBEEF then mflo the next cycle (e_rdsel=0) -> e_mdrdata=0xDEADBEEF, busy never asserted. e_valid=0 with e_mdop=1 -> start=0, no change.
